// File: rtl/npu_matmul_core.sv
// Signed DIMxDIM matrix multiply (C = A x B) behind a word-wide operand/result port.
// One MAC per cycle, one store cycle per element; optional ReLU and saturation with sticky overflow.
module npu_matmul_core #(
    parameter int DIM    = 4,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16,
    parameter int ACC_W  = 2*DATA_W + $clog2(DIM),
    parameter int AW     = $clog2(DIM*DIM)
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESET,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              relu_en,
    input  logic              sat_en,
    input  logic              clear_done,
    input  logic [AW-1:0]     rd_addr,
    output logic [OUT_W-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic              wr_err
);
    localparam int NE = DIM*DIM;
    localparam int IW = $clog2(DIM);
    localparam int XW = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic [IW-1:0] LAST = IW'(DIM-1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_STORE, S_DONE} state_t;

    state_t                   r_state;
    logic [IW-1:0]            r_i;
    logic [IW-1:0]            r_j;
    logic [IW-1:0]            r_k;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_ovf;
    logic                     r_relu;
    logic                     r_sat;
    logic                     r_wr_err;
    logic [OUT_W-1:0]         r_rd_data;
    logic signed [DATA_W-1:0] r_mem_a [NE];
    logic signed [DATA_W-1:0] r_mem_b [NE];
    logic [OUT_W-1:0]         r_mem_c [NE];

    logic [AW-1:0]              w_a_idx;
    logic [AW-1:0]              w_b_idx;
    logic [AW-1:0]              w_c_idx;
    logic signed [DATA_W-1:0]   w_a;
    logic signed [DATA_W-1:0]   w_b;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_relu;
    logic signed [XW-1:0]       w_ext;
    logic                       w_over;
    logic [OUT_W-1:0]           w_post;

    assign w_a_idx    = AW'(r_i) * AW'(DIM) + AW'(r_k);
    assign w_b_idx    = AW'(r_k) * AW'(DIM) + AW'(r_j);
    assign w_c_idx    = AW'(r_i) * AW'(DIM) + AW'(r_j);
    assign w_a        = r_mem_a[w_a_idx];
    assign w_b        = r_mem_b[w_b_idx];
    assign w_prod     = w_a * w_b;
    assign w_prod_ext = ACC_W'(w_prod);

    // Result fits OUT_W only if every bit from OUT_W-1 upward is a copy of the sign.
    assign w_relu = (r_relu && r_acc[ACC_W-1]) ? '0 : r_acc;
    assign w_ext  = XW'(w_relu);
    assign w_over = ~((&w_ext[XW-1:OUT_W-1]) | ~(|w_ext[XW-1:OUT_W-1]));

    always_comb begin
        w_post = w_ext[OUT_W-1:0];
        if (w_over && r_sat) begin
            w_post = w_ext[XW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int n = 0; n < NE; n++) begin
                r_mem_a[n] <= '0;
                r_mem_b[n] <= '0;
            end
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr_en && r_busy;
            if (wr_en && !r_busy) begin
                if (wr_sel) r_mem_b[wr_addr] <= $signed(wr_data);
                else        r_mem_a[wr_addr] <= $signed(wr_data);
            end
        end
    end

    // Read port samples C before this cycle's store, so it lags the store by one cycle.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int n = 0; n < NE; n++) r_mem_c[n] <= '0;
            r_rd_data <= '0;
        end else begin
            if (r_state == S_STORE) r_mem_c[w_c_idx] <= w_post;
            r_rd_data <= r_mem_c[rd_addr];
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_relu  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            if (clear_done) begin
                r_done <= 1'b0;
                r_ovf  <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_relu  <= relu_en;
                        r_sat   <= sat_en;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_acc   <= '0;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_k == LAST) r_state <= S_STORE;
                    else             r_k     <= r_k + IW'(1);
                end
                S_STORE: begin
                    r_acc <= '0;
                    r_k   <= '0;
                    if (w_over) r_ovf <= 1'b1;
                    if (r_j == LAST) begin
                        r_j <= '0;
                        if (r_i == LAST) begin
                            r_i     <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_i     <= r_i + IW'(1);
                            r_state <= S_MAC;
                        end
                    end else begin
                        r_j     <= r_j + IW'(1);
                        r_state <= S_MAC;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_data = r_rd_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ovf     = r_ovf;
    assign wr_err  = r_wr_err;

endmodule
